pc_sequencer: RTL and testbench

- Owns the program counter and the instruction-fetch handshake for the 16-bit multicycle core.
- Consumes the branch-take decision and targets from the execute side (branch controller output, jump logic).
- Sequences each instruction: fetch from instruction memory, hand it to the datapath, wait for execute completion, then redirect or increment the PC.

---
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer for the 16-bit multicycle core.
// Optional retire/taken statistics counters are enabled with `define PC_SEQ_STATS_EN.
module pc_sequencer #(
  parameter int unsigned     XLEN     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instr,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic            take_branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            redirect
`ifdef PC_SEQ_STATS_EN
  ,
  output logic [15:0]     retired_cnt,
  output logic [15:0]     taken_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_ACK = 2'd1,
    EXEC     = 2'd2
  } state_t;

  state_t state;

  // pc is only ever updated at the completion edge, so it doubles as the fetch address.
  assign imem_addr = pc;
  assign pc_plus   = pc + XLEN'(PC_STEP);

  // Fetch / wait-for-ack / execute sequencing with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      redirect    <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      redirect    <= 1'b0;
      unique case (state)
        FETCH: begin
          if (!stall) begin
            imem_req <= 1'b1;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (exec_done) begin
            if (jump) begin
              pc <= jump_target;
            end else if (take_branch) begin
              pc <= branch_target;
            end else begin
              pc <= pc_plus;
            end
            redirect <= jump | take_branch;
            state    <= FETCH;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= FETCH;
        end
      endcase
    end
  end

`ifdef PC_SEQ_STATS_EN
  logic retire_c;
  logic taken_c;

  assign retire_c = (state == EXEC) && exec_done;
  assign taken_c  = retire_c && (jump || take_branch);

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      taken_cnt   <= '0;
    end else begin
      if (retire_c && (retired_cnt != 16'hFFFF)) begin
        retired_cnt <= retired_cnt + 16'd1;
      end
      if (taken_c && (taken_cnt != 16'hFFFF)) begin
        taken_cnt <= taken_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed and randomized instruction transactions checked
// against a per-instruction model of the expected PC, handshake and pulse behaviour.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        take_branch;
  logic [15:0] branch_target;
  logic        jump;
  logic [15:0] jump_target;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic        redirect;
`ifdef PC_SEQ_STATS_EN
  logic [15:0] retired_cnt;
  logic [15:0] taken_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_pc;
  int          exp_ret;
  int          exp_tak;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .take_branch   (take_branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .redirect      (redirect)
`ifdef PC_SEQ_STATS_EN
    ,
    .retired_cnt   (retired_cnt),
    .taken_cnt     (taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats();
`ifdef PC_SEQ_STATS_EN
    chk("retired_cnt", 32'(retired_cnt), 32'(exp_ret));
    chk("taken_cnt", 32'(taken_cnt), 32'(exp_tak));
`endif
  endtask

  // Drive ignored inputs with random values to show they have no effect.
  task automatic noise();
    exec_done     = 1'($urandom);
    take_branch   = 1'($urandom);
    jump          = 1'($urandom);
    branch_target = 16'($urandom);
    jump_target   = 16'($urandom);
    imem_ack      = 1'($urandom);
    imem_rdata    = 16'($urandom);
  endtask

  // One complete instruction: stall, request, ack delay, execute wait, completion.
  task automatic run_instr(input int s_cyc, input int ack_dly, input logic [15:0] rdata,
                           input int ex_wait, input logic tk, input logic [15:0] bt,
                           input logic jp, input logic [15:0] jt);
    logic [15:0] nxt;
    stall = 1'b1;
    for (int i = 0; i < s_cyc; i++) begin
      noise();
      tick();
      chk("stall_no_req", 32'(imem_req), 32'd0);
      chk("stall_pc", 32'(pc), 32'(exp_pc));
      chk("redirect_one_cycle", 32'(redirect), 32'd0);
    end
    stall     = 1'b0;
    noise();
    tick();
    chk("req_rise", 32'(imem_req), 32'd1);
    chk("req_addr", 32'(imem_addr), 32'(exp_pc));
    chk("redirect_low", 32'(redirect), 32'd0);
    chk("pc_plus", 32'(pc_plus), 32'(16'(exp_pc + 16'd1)));
    for (int i = 0; i < ack_dly; i++) begin
      noise();
      imem_ack = 1'b0;
      stall    = 1'($urandom);
      tick();
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", 32'(imem_addr), 32'(exp_pc));
      chk("no_valid_wait", 32'(instr_valid), 32'd0);
    end
    noise();
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack = 1'b0;
    chk("valid_pulse", 32'(instr_valid), 32'd1);
    chk("instr", 32'(instr), 32'(rdata));
    chk("req_drop", 32'(imem_req), 32'd0);
    chk("pc_hold_ack", 32'(pc), 32'(exp_pc));
    for (int i = 0; i < ex_wait; i++) begin
      noise();
      exec_done = 1'b0;
      tick();
      chk("valid_once", 32'(instr_valid), 32'd0);
      chk("instr_stable", 32'(instr), 32'(rdata));
      chk("pc_hold_exec", 32'(pc), 32'(exp_pc));
      chk("req_low_exec", 32'(imem_req), 32'd0);
    end
    imem_ack      = 1'($urandom);
    exec_done     = 1'b1;
    take_branch   = tk;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    nxt = jp ? jt : (tk ? bt : 16'(exp_pc + 16'd1));
    tick();
    exec_done   = 1'b0;
    take_branch = 1'b0;
    jump        = 1'b0;
    imem_ack    = 1'b0;
    exp_pc = nxt;
    if (exp_ret < 65535) exp_ret++;
    if ((jp || tk) && exp_tak < 65535) exp_tak++;
    chk("pc_next", 32'(pc), 32'(exp_pc));
    chk("redirect", 32'(redirect), 32'(jp | tk));
    chk("pc_plus_next", 32'(pc_plus), 32'(16'(exp_pc + 16'd1)));
    chk("req_low_done", 32'(imem_req), 32'd0);
    chk("valid_low_done", 32'(instr_valid), 32'd0);
    chk_stats();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; take_branch = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    exp_pc = 16'h0000; exp_ret = 0; exp_tak = 0;
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_instr", 32'(instr), 32'h0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_pc_plus", 32'(pc_plus), 32'h0001);
    chk_stats();
    rst_n = 1'b1;

    run_instr(0, 1, 16'h1234, 0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    run_instr(0, 0, 16'h5555, 1, 1'b0, 16'h0000, 1'b1, 16'h0010);
    run_instr(0, 1, 16'hA0A0, 0, 1'b1, 16'h0040, 1'b0, 16'h0000);
    run_instr(0, 0, 16'h0F0F, 0, 1'b1, 16'h0200, 1'b1, 16'h0100);
    run_instr(0, 0, 16'h1111, 0, 1'b0, 16'h0000, 1'b1, 16'hFFFF);
    run_instr(0, 0, 16'h2222, 0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    run_instr(3, 4, 16'hBEEF, 2, 1'b0, 16'h0000, 1'b0, 16'h0000);
    run_instr(0, 0, 16'h3333, 0, 1'b1, exp_pc, 1'b0, 16'h0000);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] bt;
      logic [15:0] jt;
      bt = ($urandom_range(0, 7) == 0) ? exp_pc : 16'($urandom);
      jt = 16'($urandom);
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 16'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0), bt,
                1'($urandom_range(0, 3) == 0), jt);
    end

    // Asynchronous reset while a request is outstanding.
    stall = 1'b0;
    tick();
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 16'hDEAD;
    rst_n      = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_pc", 32'(pc), 32'h0000);
    exp_pc = 16'h0000; exp_ret = 0; exp_tak = 0;
    chk_stats();
    tick();
    chk("rst_no_latch", 32'(instr), 32'h0000);
    chk("rst_no_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    run_instr(0, 0, 16'h4321, 0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    run_instr(1, 2, 16'h6789, 1, 1'b1, 16'h0033, 1'b0, 16'h0000);
    run_instr(0, 0, 16'h9ABC, 0, 1'b0, 16'h0000, 1'b0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
